mem_arbiter: RTL

- Shares one single-port synchronous RAM between the core's instruction-fetch port and data-memory port, so the core can run from a unified memory.
- Each port uses a req/ack handshake. The core stalls its PC while a fetch is unacknowledged.
- Arbitration is round-robin. A small FSM sequences issue, read-latency wait, and acknowledge.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction-fetch (IF) and data-memory (DM) ports of the core.
module mem_arbiter #(
    parameter int p_WORD_LEN   = 16,
    parameter int p_ADDR_LEN   = 16,
    parameter int p_RD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_if_req,
    input  logic [p_ADDR_LEN-1:0] i_if_addr,
    output logic                  o_if_ack,
    output logic [p_WORD_LEN-1:0] o_if_rd_data,
    input  logic                  i_dm_req,
    input  logic                  i_dm_wr_en,
    input  logic [p_ADDR_LEN-1:0] i_dm_addr,
    input  logic [p_WORD_LEN-1:0] i_dm_wr_data,
    output logic                  o_dm_ack,
    output logic [p_WORD_LEN-1:0] o_dm_rd_data,
    output logic                  o_mem_en,
    output logic                  o_mem_wr_en,
    output logic [p_ADDR_LEN-1:0] o_mem_addr,
    output logic [p_WORD_LEN-1:0] o_mem_wr_data,
    input  logic [p_WORD_LEN-1:0] i_mem_rd_data,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    localparam logic [1:0] LAT_LOAD = 2'(p_RD_LATENCY - 1);

    state_t                state_r;
    state_t                state_next_s;
    logic [1:0]            lat_cnt_r;
    logic [1:0]            lat_cnt_next_s;
    logic                  win_dm_r;
    logic                  win_dm_next_s;
    logic                  last_dm_r;
    logic                  last_dm_next_s;
    logic [p_ADDR_LEN-1:0] addr_r;
    logic [p_ADDR_LEN-1:0] addr_next_s;
    logic                  wr_en_r;
    logic                  wr_en_next_s;
    logic [p_WORD_LEN-1:0] wr_data_r;
    logic [p_WORD_LEN-1:0] wr_data_next_s;
    logic                  pick_dm_s;
    logic                  capture_s;

    // Next-state, winner selection and command latching
    always_comb begin
        state_next_s   = state_r;
        lat_cnt_next_s = lat_cnt_r;
        win_dm_next_s  = win_dm_r;
        last_dm_next_s = last_dm_r;
        addr_next_s    = addr_r;
        wr_en_next_s   = wr_en_r;
        wr_data_next_s = wr_data_r;
        capture_s      = 1'b0;
        // On a tie the port that did not win last time gets the grant
        pick_dm_s      = i_dm_req && (!i_if_req || !last_dm_r);

        case (state_r)
            S_IDLE: begin
                if (i_if_req || i_dm_req) begin
                    win_dm_next_s  = pick_dm_s;
                    last_dm_next_s = pick_dm_s;
                    state_next_s   = S_ISSUE;
                    if (pick_dm_s) begin
                        addr_next_s    = i_dm_addr;
                        wr_en_next_s   = i_dm_wr_en;
                        wr_data_next_s = i_dm_wr_data;
                    end else begin
                        addr_next_s    = i_if_addr;
                        wr_en_next_s   = 1'b0;
                        wr_data_next_s = {p_WORD_LEN{1'b0}};
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (wr_en_r) begin
                    state_next_s = S_ACK;
                end else begin
                    lat_cnt_next_s = LAT_LOAD;
                    state_next_s   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_r != 2'd0) begin
                    lat_cnt_next_s = lat_cnt_r - 2'd1;
                end else begin
                    capture_s    = 1'b1;
                    state_next_s = S_ACK;
                end
            end
            S_ACK: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase
    end

    // State, latched command and registered outputs (derived from next state)
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= S_IDLE;
            lat_cnt_r     <= 2'd0;
            win_dm_r      <= 1'b0;
            last_dm_r     <= 1'b1;
            addr_r        <= {p_ADDR_LEN{1'b0}};
            wr_en_r       <= 1'b0;
            wr_data_r     <= {p_WORD_LEN{1'b0}};
            o_if_ack      <= 1'b0;
            o_dm_ack      <= 1'b0;
            o_if_rd_data  <= {p_WORD_LEN{1'b0}};
            o_dm_rd_data  <= {p_WORD_LEN{1'b0}};
            o_mem_en      <= 1'b0;
            o_mem_wr_en   <= 1'b0;
            o_mem_addr    <= {p_ADDR_LEN{1'b0}};
            o_mem_wr_data <= {p_WORD_LEN{1'b0}};
            o_busy        <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            lat_cnt_r     <= lat_cnt_next_s;
            win_dm_r      <= win_dm_next_s;
            last_dm_r     <= last_dm_next_s;
            addr_r        <= addr_next_s;
            wr_en_r       <= wr_en_next_s;
            wr_data_r     <= wr_data_next_s;
            o_if_ack      <= (state_next_s == S_ACK) && !win_dm_r;
            o_dm_ack      <= (state_next_s == S_ACK) && win_dm_r;
            o_mem_en      <= (state_next_s == S_ISSUE);
            o_mem_wr_en   <= (state_next_s == S_ISSUE) && wr_en_next_s;
            o_mem_addr    <= addr_next_s;
            o_mem_wr_data <= wr_data_next_s;
            o_busy        <= (state_next_s != S_IDLE);
            if (capture_s && !win_dm_r) begin
                o_if_rd_data <= i_mem_rd_data;
            end
            if (capture_s && win_dm_r) begin
                o_dm_rd_data <= i_mem_rd_data;
            end
        end
    end

endmodule
